microwave_cook_controller: RTL
==============================

# microwave_cook_controller

Top-level cook sequencer for the microwave. It sits beside `timer_input_control`: it drives that block's `EN_N`, and takes its `D`, `LOAD_N` and `CLK_1HZ` outputs back in. While the keypad is enabled, rising edges of `CLK_1HZ` (the debounced key strobe) shift BCD digits into an MM:SS register. While cooking, rising edges of `CLK_1HZ` (1 Hz) count that register down to 00:00, with the magnetron enabled.

## Interface
- No parameters.
- `CLK_100HZ`  in  1  system clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `D`  in  4  BCD key digit from `timer_input_control`.
- `LOAD_N`  in  1  key-valid, active low; digit capture requires `LOAD_N`=0.
- `CLK_1HZ`  in  1  key strobe when `EN_N`=0; 1 Hz tick when `EN_N`=1.
- `START_N`  in  1  start button, active low, asynchronous.
- `STOP_N`  in  1  stop/clear button, active low, asynchronous.
- `DOOR_CLOSED`  in  1  door switch, 1 = closed, asynchronous.
- `EN_N`  out  1  keypad enable to `timer_input_control`; 0 = keypad active.
- `MAG_ON`  out  1  magnetron enable.
- `DONE`  out  1  cook-complete indicator.
- `MIN_T`, `MIN_U`, `SEC_T`, `SEC_U`  out  4 each  BCD time digits for the display.

## Operation
- `START_N`, `STOP_N` and `DOOR_CLOSED` pass through 2-flop synchronizers (reset values 1, 1, 0).
- Button events are falling edges of the synchronized signals. Previous-value registers reset to 1.
- Tick/strobe event: `CLK_1HZ` sampled 1 at the current edge and 0 at the previous edge (previous-value register resets to 0).
- Events are masked for 1 cycle after any change of `EN_N`, to suppress mux-switch glitches.
- States: IDLE, ENTRY, RUN, PAUSE, FINISH. Reset: IDLE, all digits 0, `EN_N`=0, `MAG_ON`=0, `DONE`=0.
- Digit capture happens in IDLE/ENTRY, on a strobe event with `LOAD_N`=0 and `D`≤9:
  - shift left: `MIN_T`←`MIN_U`, `MIN_U`←`SEC_T`, `SEC_T`←`SEC_U`, `SEC_U`←`D`; the old `MIN_T` is discarded;
  - from IDLE, go to ENTRY.
  - `D`>9 or `LOAD_N`=1: ignored.
- ENTRY:
  - stop event → clear digits, go to IDLE;
  - start event with door closed and time ≠ 00:00 → RUN;
  - otherwise start is ignored.
- RUN (`EN_N`=1, `MAG_ON`=1):
  - stop event or door open → PAUSE;
  - else tick event → BCD decrement.
- Decrement rules:
  - `SEC_U` borrows from `SEC_T`; `SEC_T`=0 with `SEC_U`=0 borrows from minutes and loads SS=59.
  - Minutes decrement as a 2-digit BCD value.
  - Entered seconds above 59 (e.g. 01:75) count down unnormalized: 75…00, then 00:59.
  - The result 00:00 → FINISH in the same cycle.
- PAUSE (`EN_N`=1, `MAG_ON`=0):
  - stop event → clear, go to IDLE;
  - start event with door closed → RUN;
  - ticks ignored.
- FINISH (`EN_N`=1, `MAG_ON`=0, `DONE`=1): stop event or door open → IDLE with `DONE`=0.
- Priority within a cycle: stop > door open > start > tick/strobe.
- All outputs are registered, Moore-style, and decoded from the next-state register.

## Timing
- Button/door latency:
  - synchronizer: 2 cycles;
  - edge detection: same edge as the first synchronized low/high;
  - state and outputs update on that edge.
- Start pressed (async) → `MAG_ON`=1 within 3 `CLK_100HZ` cycles; door open → `MAG_ON`=0 within 3 cycles.
- Tick: digits update on the first edge that samples `CLK_1HZ`=1; one decrement per `CLK_1HZ` high pulse regardless of its width.
- A final tick reaching 00:00 asserts `DONE` and deasserts `MAG_ON` on the same edge that writes 00:00.
- `RST` asserted asynchronously clears all state immediately, including mid-RUN (`MAG_ON` drops without waiting for a clock).

## Test plan
- Reset, then strobes with `D`=1,3,0: display 01:30, state ENTRY, `EN_N`=0.
- Entry of 5 digits 1,2,3,4,5: display 23:45; `D`=12 strobe ignored.
- 00:03 entered, start with door closed, 1 Hz ticks: sequence 00:02, 00:01, 00:00; `MAG_ON` 1→0 and `DONE`=1 on the 3rd tick.
- 01:00 running:
  - one tick → 00:59;
  - door opens → PAUSE, `MAG_ON`=0, next ticks ignored;
  - door closed plus start → resumes at 00:59.
- Same-cycle stop and tick in RUN at 00:10 → PAUSE, display stays 00:10; a second stop → IDLE, 00:00.
- Start at 00:00 or with door open → stays IDLE/ENTRY, `MAG_ON`=0; `RST` mid-RUN → all outputs at reset values before the next clock.

Source files
------------

// File: rtl/microwave_cook_controller.sv
// Cook sequencer for the microwave: captures BCD keypad digits into an MM:SS
// register, then counts it down at 1 Hz with the magnetron enabled.
module microwave_cook_controller (
  input  logic       CLK_100HZ,
  input  logic       RST,
  input  logic [3:0] D,
  input  logic       LOAD_N,
  input  logic       CLK_1HZ,
  input  logic       START_N,
  input  logic       STOP_N,
  input  logic       DOOR_CLOSED,
  output logic       EN_N,
  output logic       MAG_ON,
  output logic       DONE,
  output logic [3:0] MIN_T,
  output logic [3:0] MIN_U,
  output logic [3:0] SEC_T,
  output logic [3:0] SEC_U
);

  typedef enum logic [2:0] {IDLE, ENTRY, RUN, PAUSE, FINISH} stateT;

  stateT      state_q, state_d;
  logic [3:0] minT_q, minU_q, secT_q, secU_q;
  logic [3:0] minT_d, minU_d, secT_d, secU_d;
  logic [3:0] decMinT, decMinU, decSecT, decSecU;
  logic       startMeta_q, startSync_q, startPrev_q;
  logic       stopMeta_q, stopSync_q, stopPrev_q;
  logic       doorMeta_q, doorSync_q;
  logic       tickPrev_q, enNPrev_q;
  logic       enN_q, magOn_q, done_q;
  logic       eventMask, startEvt, stopEvt, tickEvt;
  logic       digitOk, timeZero, decZero;

  // Two-flop synchronizers for the asynchronous buttons and door switch.
  always_ff @(posedge CLK_100HZ or posedge RST) begin
    if (RST) begin
      startMeta_q <= 1'b1;
      startSync_q <= 1'b1;
      stopMeta_q  <= 1'b1;
      stopSync_q  <= 1'b1;
      doorMeta_q  <= 1'b0;
      doorSync_q  <= 1'b0;
      startPrev_q <= 1'b1;
      stopPrev_q  <= 1'b1;
      tickPrev_q  <= 1'b0;
      enNPrev_q   <= 1'b0;
    end else begin
      startMeta_q <= START_N;
      startSync_q <= startMeta_q;
      stopMeta_q  <= STOP_N;
      stopSync_q  <= stopMeta_q;
      doorMeta_q  <= DOOR_CLOSED;
      doorSync_q  <= doorMeta_q;
      startPrev_q <= startSync_q;
      stopPrev_q  <= stopSync_q;
      tickPrev_q  <= CLK_1HZ;
      enNPrev_q   <= enN_q;
    end
  end

  // The CLK_1HZ mux in timer_input_control follows EN_N, so the cycle after
  // EN_N toggles may carry a spurious edge; all events are ignored there.
  assign eventMask = enN_q ^ enNPrev_q;
  assign startEvt  = startPrev_q & ~startSync_q & ~eventMask;
  assign stopEvt   = stopPrev_q & ~stopSync_q & ~eventMask;
  assign tickEvt   = CLK_1HZ & ~tickPrev_q & ~eventMask;
  assign digitOk   = ~LOAD_N && (D <= 4'd9);
  assign timeZero  = (minT_q == 4'd0) && (minU_q == 4'd0) &&
                     (secT_q == 4'd0) && (secU_q == 4'd0);

  // Seconds above 59 are left unnormalized and simply count down digit-wise.
  always_comb begin
    decMinT = minT_q;
    decMinU = minU_q;
    decSecT = secT_q;
    decSecU = secU_q;
    if (secU_q != 4'd0) begin
      decSecU = secU_q - 4'd1;
    end else if (secT_q != 4'd0) begin
      decSecT = secT_q - 4'd1;
      decSecU = 4'd9;
    end else begin
      decSecT = 4'd5;
      decSecU = 4'd9;
      if (minU_q != 4'd0) begin
        decMinU = minU_q - 4'd1;
      end else begin
        decMinU = 4'd9;
        decMinT = minT_q - 4'd1;
      end
    end
  end

  assign decZero = (decMinT == 4'd0) && (decMinU == 4'd0) &&
                   (decSecT == 4'd0) && (decSecU == 4'd0);

  always_comb begin
    state_d = state_q;
    minT_d  = minT_q;
    minU_d  = minU_q;
    secT_d  = secT_q;
    secU_d  = secU_q;
    case (state_q)
      IDLE, ENTRY: begin
        if (stopEvt) begin
          state_d = IDLE;
          minT_d  = 4'd0;
          minU_d  = 4'd0;
          secT_d  = 4'd0;
          secU_d  = 4'd0;
        end else if ((state_q == ENTRY) && startEvt && doorSync_q && !timeZero) begin
          state_d = RUN;
        end else if (tickEvt && digitOk) begin
          state_d = ENTRY;
          minT_d  = minU_q;
          minU_d  = secT_q;
          secT_d  = secU_q;
          secU_d  = D;
        end
      end
      RUN: begin
        if (stopEvt || !doorSync_q) begin
          state_d = PAUSE;
        end else if (tickEvt) begin
          minT_d = decMinT;
          minU_d = decMinU;
          secT_d = decSecT;
          secU_d = decSecU;
          if (decZero) state_d = FINISH;
        end
      end
      PAUSE: begin
        if (stopEvt) begin
          state_d = IDLE;
          minT_d  = 4'd0;
          minU_d  = 4'd0;
          secT_d  = 4'd0;
          secU_d  = 4'd0;
        end else if (startEvt && doorSync_q) begin
          state_d = RUN;
        end
      end
      FINISH: begin
        if (stopEvt || !doorSync_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_ff @(posedge CLK_100HZ or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      minT_q  <= 4'd0;
      minU_q  <= 4'd0;
      secT_q  <= 4'd0;
      secU_q  <= 4'd0;
      enN_q   <= 1'b0;
      magOn_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      minT_q  <= minT_d;
      minU_q  <= minU_d;
      secT_q  <= secT_d;
      secU_q  <= secU_d;
      enN_q   <= !((state_d == IDLE) || (state_d == ENTRY));
      magOn_q <= (state_d == RUN);
      done_q  <= (state_d == FINISH);
    end
  end

  assign EN_N   = enN_q;
  assign MAG_ON = magOn_q;
  assign DONE   = done_q;
  assign MIN_T  = minT_q;
  assign MIN_U  = minU_q;
  assign SEC_T  = secT_q;
  assign SEC_U  = secU_q;

endmodule
